// File: rtl/bcd_to_bin.sv
// Converts a four-digit BCD value to binary by reverse double dabble.
// Latency: 16 SHIFT cycles plus 1 DONE cycle; a bad digit goes straight to DONE.
// Backpressure: none; start is only taken in IDLE and is dropped while busy.
module bcd_to_bin (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  thous,
  input  logic [3:0]  hunds,
  input  logic [3:0]  tens,
  input  logic [3:0]  ones,
  output logic [15:0] freq,
  output logic        done,
  output logic        busy,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [15:0] bcd_q;
  logic [15:0] bin_q;
  logic [3:0]  cnt_q;
  logic        digits_ok;
  logic [31:0] shifted;
  logic [15:0] bcd_adj;

  assign digits_ok = (thous <= 4'd9) && (hunds <= 4'd9) &&
                     (tens  <= 4'd9) && (ones  <= 4'd9);

  assign shifted = {bcd_q, bin_q} >> 1;

  // A digit that gained 8 from the shift gained only 5 in decimal terms.
  always_comb begin
    bcd_adj = shifted[31:16];
    for (int i = 0; i < 4; i++) begin
      if (shifted[16+4*i +: 4] >= 4'd8) begin
        bcd_adj[4*i +: 4] = shifted[16+4*i +: 4] - 4'd3;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = digits_ok ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        if (cnt_q == 4'd15) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bcd_q <= 16'd0;
      bin_q <= 16'd0;
      cnt_q <= 4'd0;
      freq  <= 16'd0;
      err   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            if (digits_ok) begin
              bcd_q <= {thous, hunds, tens, ones};
              bin_q <= 16'd0;
              cnt_q <= 4'd0;
              err   <= 1'b0;
            end else begin
              err   <= 1'b1;
            end
          end
        end
        SHIFT: begin
          bcd_q <= bcd_adj;
          bin_q <= shifted[15:0];
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            freq <= shifted[15:0];
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign done = (state_q == DONE);
  assign busy = (state_q != IDLE);

endmodule
